// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter that shares one single-port data memory among NUM_CORES cores.
// Grants one LOAD/STORE at a time, waits out the read latency and returns a one-cycle ack.
module core_mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CORES-1:0]       core_req,
    input  logic [NUM_CORES*4-1:0]     core_op,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]       core_ack,
    output logic                       core_err,
    output logic [DATA_W-1:0]          core_rdata,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       busy
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [3:0] OP_LOAD  = 4'b0101;
    localparam logic [3:0] OP_STORE = 4'b0110;
    localparam logic [NUM_CORES-1:0] ONE_HOT0 = NUM_CORES'(1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       rr_q;
    logic [IDX_W-1:0]       sel_q;
    logic [2:0]             lat_q;
    logic [NUM_CORES-1:0]   ack_q;
    logic                   err_q;
    logic [DATA_W-1:0]      rdata_q;
    logic                   mem_en_q;
    logic                   mem_we_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [DATA_W-1:0]      mem_wdata_q;
    logic                   busy_q;

    logic                   grant_vld_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic [IDX_W-1:0]       cand_s;
    logic [3:0]             grant_op_s;
    logic [ADDR_W-1:0]      grant_addr_s;
    logic [DATA_W-1:0]      grant_wdata_s;
    logic                   grant_legal_s;

    // Round-robin pick: scanning downward lets the candidate closest to rr_q win.
    always_comb begin
        grant_vld_s = |core_req;
        grant_idx_s = '0;
        cand_s      = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            cand_s      = IDX_W'((int'(rr_q) + k) % NUM_CORES);
            grant_idx_s = core_req[cand_s] ? cand_s : grant_idx_s;
        end
        grant_op_s    = core_op[int'(grant_idx_s)*4 +: 4];
        grant_addr_s  = core_addr[int'(grant_idx_s)*ADDR_W +: ADDR_W];
        grant_wdata_s = core_wdata[int'(grant_idx_s)*DATA_W +: DATA_W];
        grant_legal_s = (grant_op_s == OP_LOAD) || (grant_op_s == OP_STORE);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            sel_q       <= '0;
            lat_q       <= 3'd0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld_s) begin
                        sel_q   <= grant_idx_s;
                        rdata_q <= '0;
                        busy_q  <= 1'b1;
                        if (grant_legal_s) begin
                            state_q     <= ACCESS;
                            err_q       <= 1'b0;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= (grant_op_s == OP_STORE);
                            mem_addr_q  <= grant_addr_s;
                            mem_wdata_q <= grant_wdata_s;
                        end else begin
                            state_q <= ACK;
                            err_q   <= 1'b1;
                            ack_q   <= ONE_HOT0 << grant_idx_s;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (mem_we_q) begin
                        state_q <= ACK;
                        ack_q   <= ONE_HOT0 << sel_q;
                    end else begin
                        state_q <= WAIT;
                        lat_q   <= 3'(RD_LAT);
                    end
                end
                WAIT: begin
                    lat_q <= lat_q - 3'd1;
                    if (lat_q == 3'd1) begin
                        rdata_q <= mem_rdata;
                        state_q <= ACK;
                        ack_q   <= ONE_HOT0 << sel_q;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                ACK: begin
                    ack_q   <= '0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    rr_q    <= (sel_q == IDX_W'(NUM_CORES - 1)) ? '0 : sel_q + IDX_W'(1);
                    state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    ack_q    <= '0;
                    err_q    <= 1'b0;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign core_ack   = ack_q;
    assign core_err   = err_q;
    assign core_rdata = rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios plus random traffic checked against a
// transaction-level model (grant order, ack cycle, memory port and returned data).
module tb_core_mem_arbiter;

    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam logic [3:0] LOAD  = 4'b0101;
    localparam logic [3:0] STORE = 4'b0110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [N-1:0]      core_req;
    logic [N*4-1:0]    core_op;
    logic [N*AW-1:0]   core_addr;
    logic [N*DW-1:0]   core_wdata;
    logic [N-1:0]      core_ack;
    logic              core_err;
    logic [DW-1:0]     core_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              busy;

    logic [3:0]        op_a   [N];
    logic [AW-1:0]     addr_a [N];
    logic [DW-1:0]     wd_a   [N];
    bit                pend   [N];
    bit                done   [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            core_op[i*4 +: 4]     = op_a[i];
            core_addr[i*AW +: AW] = addr_a[i];
            core_wdata[i*DW +: DW] = wd_a[i];
        end
    end

    core_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .core_req(core_req), .core_op(core_op),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_ack(core_ack),
        .core_err(core_err), .core_rdata(core_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: one transaction record plus a shadow memory
    int            rr = 0, start_cyc = -1, acc_cyc = -1, ack_cyc = -1, t_idx = 0;
    bit            t_we, t_err, post_rst;
    logic [AW-1:0] t_addr, e_addr;
    logic [DW-1:0] t_wd, e_wd, t_data;
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] env_mem [256];
    logic [DW-1:0] pipe    [LAT];
    int            grants[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    task automatic model_cycle();
        bit           e_en;
        logic [N-1:0] e_ack;
        int           w;
        e_en = (cyc == acc_cyc);
        if (e_en) begin
            e_addr = t_addr;
            e_wd   = t_wd;
        end
        check_eq("busy", 32'(busy), 32'(cyc > start_cyc && cyc <= ack_cyc));
        check_eq("mem_en", 32'(mem_en), 32'(e_en));
        check_eq("mem_we", 32'(mem_we), 32'(e_en && t_we));
        check_eq("mem_addr", 32'(mem_addr), 32'(e_addr));
        check_eq("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        e_ack = (cyc == ack_cyc) ? (N'(1) << t_idx) : '0;
        check_eq("core_ack", 32'(core_ack), 32'(e_ack));
        if (cyc == ack_cyc) begin
            check_eq("core_err", 32'(core_err), 32'(t_err));
            check_eq("core_rdata", 32'(core_rdata), 32'(t_data));
            done[t_idx] = 1'b1;
            grants.push_back(t_idx);
        end
        if (post_rst) begin
            check_eq("rst_rdata", 32'(core_rdata), 32'd0);
            check_eq("rst_err", 32'(core_err), 32'd0);
            post_rst = 1'b0;
        end
        if (!rst_n) begin
            rr = 0; start_cyc = -1; acc_cyc = -1; ack_cyc = -1;
            e_addr = '0; e_wd = '0; post_rst = 1'b1;
        end else if (cyc > ack_cyc && core_req != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && core_req[(rr + k) % N]) w = (rr + k) % N;
            end
            t_idx = w; start_cyc = cyc; rr = (w + 1) % N;
            t_addr = addr_a[w]; t_wd = wd_a[w];
            if (op_a[w] == LOAD || op_a[w] == STORE) begin
                t_err = 1'b0;
                t_we = (op_a[w] == STORE);
                acc_cyc = cyc + 1;
                ack_cyc = cyc + 2 + (t_we ? 0 : LAT);
                if (t_we) begin
                    ref_mem[t_addr] = t_wd;
                    t_data = '0;
                end else begin
                    t_data = ref_mem[t_addr];
                end
            end else begin
                t_err = 1'b1; t_we = 1'b0; t_data = '0;
                acc_cyc = -1; ack_cyc = cyc + 1;
            end
        end
    endtask

    // One clock cycle: check at negedge, then update the memory environment after posedge
    task automatic tick();
        bit            s_en, s_we;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_wd;
        @(negedge clk);
        s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata;
        model_cycle();
        @(posedge clk);
        #1;
        if (s_en && s_we) env_mem[s_addr] = s_wd;
        for (int i = 0; i < LAT - 1; i++) pipe[i] = pipe[i+1];
        pipe[LAT-1] = (s_en && !s_we) ? env_mem[s_addr] : DW'($urandom);
        mem_rdata = pipe[0];
        cyc++;
    endtask

    task automatic issue(input int i, input logic [3:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_a[i] = op; addr_a[i] = a; wd_a[i] = d;
        core_req[i] = 1'b1; pend[i] = 1'b1;
    endtask

    task automatic rand_issue(input int i);
        int          r;
        logic [3:0]  op;
        r  = $urandom_range(0, 9);
        op = 4'($urandom);
        if (op == LOAD || op == STORE) op = 4'b0001;
        if (r < 4) op = LOAD;
        else if (r < 8) op = STORE;
        issue(i, op, AW'($urandom_range(0, 15)), DW'($urandom));
    endtask

    task automatic retire_done();
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                done[i] = 1'b0; pend[i] = 1'b0; core_req[i] = 1'b0;
            end
        end
    endtask

    function automatic bit any_pend();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) p |= pend[i];
        return p;
    endfunction

    task automatic drain();
        int b = 0;
        while (any_pend() && b < 300) begin
            tick();
            retire_done();
            b++;
        end
        check_eq("drain_timeout", 32'(any_pend()), 32'd0);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; done[i] = 1'b0; core_req[i] = 1'b0;
        end
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n = 1'b0; core_req = '0; mem_rdata = '0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = 4'd0; addr_a[i] = '0; wd_a[i] = '0; pend[i] = 1'b0; done[i] = 1'b0;
        end
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        for (int a = 0; a < 256; a++) begin
            env_mem[a] = DW'($urandom);
            ref_mem[a] = env_mem[a];
        end
        env_mem[8'h10] = 16'h1234; ref_mem[8'h10] = 16'h1234;
        t_addr = '0; t_wd = '0; e_addr = '0; e_wd = '0; t_data = '0;
        t_we = 1'b0; t_err = 1'b0; post_rst = 1'b0;

        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Load, store, early-drop load and illegal opcode
        issue(1, LOAD, 8'h10, 16'h0000);       drain();
        issue(2, STORE, 8'h10, 16'hBEEF);      drain();
        issue(0, LOAD, 8'h10, 16'h0000);
        tick();
        core_req[0] = 1'b0;
        drain();
        issue(3, 4'b0001, 8'h22, 16'h5555);    drain();

        // Reset during WAIT with rr_ptr away from zero, then a core 0 vs core 3 contest
        issue(1, STORE, 8'h03, 16'hA5A5);      drain();
        issue(2, LOAD, 8'h05, 16'h0000);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_all();
        repeat (4) tick();
        grants.delete();
        issue(0, STORE, 8'h07, 16'h1111);
        issue(3, STORE, 8'h08, 16'h2222);
        drain();
        check_eq("post_rst_first_grant", 32'(grants.size() > 0 ? grants[0] : -1), 32'd0);

        // Continuous contention from reset
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) issue(i, STORE, AW'(i), DW'($urandom));
        tick();
        rst_n = 1'b1;
        clear_all();
        for (int i = 0; i < N; i++) issue(i, STORE, AW'(i), DW'($urandom));
        grants.delete();
        for (int b = 0; b < 100 && grants.size() < 5; b++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    done[i] = 1'b0;
                    issue(i, STORE, AW'($urandom_range(0, 15)), DW'($urandom));
                end
            end
        end
        check_eq("grant_count", 32'(grants.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < grants.size(); k++)
            check_eq("grant_order", 32'(grants[k]), 32'(exp_order[k]));
        drain();

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    done[i] = 1'b0; pend[i] = 1'b0; core_req[i] = 1'b0;
                    if ($urandom_range(0, 1) == 0) rand_issue(i);
                end else if (!pend[i]) begin
                    if ($urandom_range(0, 3) == 0) rand_issue(i);
                end else if (t_idx == i && start_cyc < cyc && cyc <= ack_cyc) begin
                    if ($urandom_range(0, 7) == 0) core_req[i] = 1'b0;
                end
            end
        end
        drain();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
